config_mem_shadowed: RTL and testbench

Parametrised, clocked successor to the per-tile frame-latch configuration memory. It captures configuration frames from the column frame bus into a shadow bank, which a commit pulse copies atomically into the active bank that drives the tile's ConfigBits. It also provides a sequenced shadow clear and optional frame readback. It sits inside each fabric tile, between the column FrameData/FrameStrobe distribution and the tile's switch-matrix and BEL configuration inputs.

---
 rtl/config_mem_shadowed_if.sv | 28 ++
 rtl/config_mem_shadowed.sv | 133 +++++++++++++
 tb/tb_config_mem_shadowed.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/config_mem_shadowed_if.sv
// Column frame bus, control strobes and status lines of one tile's shadowed configuration memory.
interface config_mem_shadowed_if #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int FrameIdxW       = 5
);
    logic [FrameBitsPerRow-1:0] FrameData;
    logic [MaxFramesPerCol-1:0] FrameStrobe;
    logic                       Commit;
    logic                       ClearReq;
    logic                       ReadEn;
    logic [FrameIdxW-1:0]       ReadIdx;
    logic [FrameBitsPerRow-1:0] ReadData;
    logic                       ReadValid;
    logic                       Busy;
    logic                       Dirty;
    logic                       WriteErr;

    modport master (
        output FrameData, FrameStrobe, Commit, ClearReq, ReadEn, ReadIdx,
        input  ReadData, ReadValid, Busy, Dirty, WriteErr
    );

    modport slave (
        input  FrameData, FrameStrobe, Commit, ClearReq, ReadEn, ReadIdx,
        output ReadData, ReadValid, Busy, Dirty, WriteErr
    );
endinterface

// File: rtl/config_mem_shadowed.sv
// Shadow/active configuration frame memory with atomic commit, sequenced shadow clear and
// optional frame readback (built only when CONFIG_READBACK_EN is defined).
module config_mem_shadowed #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 0,
    parameter int FrameIdxW       = 5,
    localparam int CfgW = (NoConfigBits > 0) ? NoConfigBits : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    config_mem_shadowed_if.slave      cfgBus,
    output logic [CfgW-1:0]           ConfigBits
);
    localparam logic [FrameIdxW-1:0] LastIdx = FrameIdxW'(MaxFramesPerCol - 1);

    typedef enum logic {IDLE, CLEAR} clearState_t;

    clearState_t state, stateNext;
    logic [FrameIdxW-1:0] cnt, cntNext;
    logic clearDone;
    logic busy;
    logic writeAny;
    logic commitOk;
    logic dirty;
    logic writeErr;

    logic [MaxFramesPerCol-1:0][FrameBitsPerRow-1:0] shadow;
    logic [MaxFramesPerCol-1:0][FrameBitsPerRow-1:0] active;
    logic [MaxFramesPerCol*FrameBitsPerRow-1:0]      activeFlat;
    logic unusedActive;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        clearDone = 1'b0;
        case (state)
            IDLE: begin
                if (cfgBus.ClearReq) begin
                    stateNext = CLEAR;
                    cntNext   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LastIdx) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                    clearDone = 1'b1;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy     = (state == CLEAR);
    assign writeAny = (|cfgBus.FrameStrobe) && !busy;
    assign commitOk = cfgBus.Commit && !busy;

    // Commit copies the pre-edge shadow, so a same-cycle write reaches active only on a later commit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow   <= '0;
            active   <= '0;
            dirty    <= 1'b0;
            writeErr <= 1'b0;
        end else begin
            if (busy) begin
                shadow[cnt] <= '0;
            end else begin
                for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                    if (cfgBus.FrameStrobe[f]) shadow[f] <= cfgBus.FrameData;
                end
            end
            if (commitOk) active <= shadow;
            if (writeAny || clearDone) dirty <= 1'b1;
            else if (commitOk)         dirty <= 1'b0;
            if (busy && (|cfgBus.FrameStrobe)) writeErr <= 1'b1;
        end
    end

    assign cfgBus.Busy     = busy;
    assign cfgBus.Dirty    = dirty;
    assign cfgBus.WriteErr = writeErr;

    assign activeFlat   = active;
    assign unusedActive = ^activeFlat;

    generate
        if (NoConfigBits > 0) begin : gCfg
            assign ConfigBits = activeFlat[NoConfigBits-1:0];
        end else begin : gNoCfg
            assign ConfigBits = '0;
        end
    endgenerate

`ifdef CONFIG_READBACK_EN
    logic [FrameBitsPerRow-1:0] readData;
    logic                       readValid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            readData  <= '0;
            readValid <= 1'b0;
        end else begin
            readValid <= cfgBus.ReadEn;
            if (cfgBus.ReadEn) begin
                readData <= ({1'b0, cfgBus.ReadIdx} < (FrameIdxW+1)'(MaxFramesPerCol))
                            ? shadow[cfgBus.ReadIdx] : '0;
            end
        end
    end

    assign cfgBus.ReadData  = readData;
    assign cfgBus.ReadValid = readValid;
`else
    logic unusedRead;
    assign unusedRead       = cfgBus.ReadEn ^ (^cfgBus.ReadIdx);
    assign cfgBus.ReadData  = '0;
    assign cfgBus.ReadValid = 1'b0;
`endif
endmodule

// File: tb/tb_config_mem_shadowed.sv
// Directed test-plan scenarios followed by random traffic, checked every cycle against a frame-array model.
module tb_config_mem_shadowed;
    localparam int F  = 20;
    localparam int W  = 32;
    localparam int IW = 5;
    localparam int NB = F * W;

    logic CLK = 1'b0;
    logic RST;
    logic [NB-1:0] ConfigBits;

    always #5 CLK = ~CLK;

    config_mem_shadowed_if #(
        .MaxFramesPerCol(F),
        .FrameBitsPerRow(W),
        .FrameIdxW(IW)
    ) bus ();

    config_mem_shadowed #(
        .MaxFramesPerCol(F),
        .FrameBitsPerRow(W),
        .NoConfigBits(NB),
        .FrameIdxW(IW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .cfgBus(bus),
        .ConfigBits(ConfigBits)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame arrays plus a count of remaining clear cycles.
    logic [W-1:0] mShadow [F];
    logic [W-1:0] mActive [F];
    logic mDirty, mErr, mValid;
    logic [W-1:0] mRdata;
    int clearLeft;

    task automatic checkEq(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic [F-1:0] strobe, input logic [W-1:0] data,
                         input logic commit, input logic clear, input logic ren,
                         input logic [IW-1:0] ridx);
        logic [W-1:0] oldShadow [F];
        logic [NB-1:0] expCfg;
        logic busyNow;
        RST             = rst;
        bus.FrameStrobe = strobe;
        bus.FrameData   = data;
        bus.Commit      = commit;
        bus.ClearReq    = clear;
        bus.ReadEn      = ren;
        bus.ReadIdx     = ridx;

        if (rst) begin
            for (int f = 0; f < F; f++) begin
                mShadow[f] = '0;
                mActive[f] = '0;
            end
            mDirty = 1'b0; mErr = 1'b0; mValid = 1'b0; mRdata = '0; clearLeft = 0;
        end else begin
            oldShadow = mShadow;
            busyNow = (clearLeft > 0);
            if (busyNow) begin
                mShadow[F - clearLeft] = '0;
                if (strobe != '0) mErr = 1'b1;
                if (clearLeft == 1) mDirty = 1'b1;
                clearLeft--;
            end else begin
                for (int f = 0; f < F; f++)
                    if (strobe[f]) mShadow[f] = data;
                if (commit) begin
                    mActive = oldShadow;
                    mDirty  = 1'b0;
                end
                if (strobe != '0) mDirty = 1'b1;
                if (clear) clearLeft = F;
            end
`ifdef CONFIG_READBACK_EN
            mValid = ren;
            if (ren) mRdata = (int'(ridx) < F) ? oldShadow[ridx] : '0;
`endif
        end

        @(posedge CLK);
        #1;
        for (int f = 0; f < F; f++) expCfg[f*W +: W] = mActive[f];
        checkEq("ConfigBits", ConfigBits, expCfg);
        checkEq("Busy", NB'(bus.Busy), NB'(clearLeft > 0));
        checkEq("Dirty", NB'(bus.Dirty), NB'(mDirty));
        checkEq("WriteErr", NB'(bus.WriteErr), NB'(mErr));
        checkEq("ReadValid", NB'(bus.ReadValid), NB'(mValid));
        if (mValid) checkEq("ReadData", NB'(bus.ReadData), NB'(mRdata));
`ifndef CONFIG_READBACK_EN
        checkEq("ReadDataOff", NB'(bus.ReadData), '0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [F-1:0] s;
        logic [W-1:0] d;
        int r;
        RST = 1'b1;
        bus.FrameStrobe = '0; bus.FrameData = '0; bus.Commit = 1'b0;
        bus.ClearReq = 1'b0; bus.ReadEn = 1'b0; bus.ReadIdx = '0;

        cycle(1'b1, '0, '0, 0, 0, 0, '0);
        cycle(1'b1, '0, '0, 0, 0, 0, '0);

        // Write frame 3, commit next cycle.
        cycle(0, F'(1) << 3, 32'hA5A5_0001, 0, 0, 0, '0);
        cycle(0, '0, '0, 1, 0, 0, '0);
        checkEq("Frame3Slice", NB'(ConfigBits[127:96]), NB'(32'hA5A5_0001));

        // Write without commit, then readback.
        cycle(0, F'(1), 32'hFFFF_FFFF, 0, 0, 0, '0);
        cycle(0, '0, '0, 0, 0, 1, 5'd0);
        idle(1);

        // Same-cycle write and commit, then a second commit.
        cycle(0, F'(1) << 1, 32'h0000_1234, 1, 0, 0, '0);
        cycle(0, '0, '0, 1, 0, 0, '0);

        // Fill all frames, clear with a stray strobe mid-sequence, then commit.
        for (int f = 0; f < F; f++) cycle(0, F'(1) << f, $urandom, 0, 0, 0, '0);
        cycle(0, '0, '0, 0, 1, 0, '0);
        idle(5);
        cycle(0, F'(1) << 4, 32'hDEAD_BEEF, 1, 1, 1, 5'd4);
        idle(F);
        cycle(0, '0, '0, 1, 0, 0, '0);

        // Reset in cycle 7 of a clear, then read every frame back.
        for (int f = 0; f < F; f++) cycle(0, F'(1) << f, $urandom, 0, 0, 0, '0);
        cycle(0, '0, '0, 0, 1, 0, '0);
        idle(6);
        cycle(1, '0, '0, 0, 0, 0, '0);
        for (int f = 0; f < F; f++) cycle(0, '0, '0, 0, 0, 1, IW'(f));

        // Multi-bit strobe and out-of-range readback.
        cycle(0, F'(3'b101), 32'h55, 0, 0, 0, '0);
        cycle(0, '0, '0, 0, 0, 1, 5'd0);
        cycle(0, '0, '0, 0, 0, 1, 5'd2);
        cycle(0, '0, '0, 0, 0, 1, 5'd25);
        cycle(0, '0, '0, 1, 0, 0, '0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      s = '0;
            else if (r < 9) s = F'(1) << $urandom_range(0, F - 1);
            else            s = F'($urandom);
            d = $urandom;
            cycle(($urandom_range(0, 199) == 0), s, d,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 1) == 0), IW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
